neighbor_expander: RTL and testbench

Expansion stage of the A* search pipeline. Accepts one node popped from the open list (coordinates plus path cost g). Generates its in-bounds, unblocked grid neighbours. Pushes each one into `open_list_queue` as (f, i, j), with f = g + 1 + h and h the heuristic distance to the goal. Sits directly upstream of the open-list write port (`i_wrt`/`i_node_*`) and honours its full flag.

---
 rtl/astar_pkg.sv | 41 ++++
 rtl/neighbor_expander_if.sv | 15 +
 rtl/heuristic_calc.sv | 27 ++
 rtl/neighbor_expander.sv | 188 ++++++++++++++++++
 tb/tb_neighbor_expander.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/astar_pkg.sv
// Shared types and direction tables for the A* expansion stage.
// NEIGHBOR_DIAG_EN selects 8-way connectivity; default is 4-way.
package astar_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StLookup,
    StPush,
    StNext,
    StDone
  } exp_state_e;

`ifdef NEIGHBOR_DIAG_EN
  localparam int unsigned NUM_DIRS = 8;

  typedef enum logic [2:0] {
    DirN, DirNE, DirE, DirSE, DirS, DirSW, DirW, DirNW
  } dir_e;

  localparam logic signed [1:0] DirDi [8] = '{2'sb00, 2'sb01, 2'sb01, 2'sb01,
                                              2'sb00, 2'sb11, 2'sb11, 2'sb11};
  localparam logic signed [1:0] DirDj [8] = '{2'sb11, 2'sb11, 2'sb00, 2'sb01,
                                              2'sb01, 2'sb01, 2'sb00, 2'sb11};
`else
  localparam int unsigned NUM_DIRS = 4;

  typedef enum logic [2:0] {
    DirN, DirE, DirS, DirW
  } dir_e;

  // Tables padded to 8 entries so a 3-bit direction index is always in range.
  localparam logic signed [1:0] DirDi [8] = '{2'sb00, 2'sb01, 2'sb00, 2'sb11,
                                              2'sb00, 2'sb00, 2'sb00, 2'sb00};
  localparam logic signed [1:0] DirDj [8] = '{2'sb11, 2'sb00, 2'sb01, 2'sb00,
                                              2'sb00, 2'sb00, 2'sb00, 2'sb00};
`endif

  localparam logic [2:0] LastDir = 3'(NUM_DIRS - 1);

endpackage

// File: rtl/neighbor_expander_if.sv
// Open-list write port: expander drives the strobe and node, the list reports full.
interface neighbor_expander_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAP_WIDTH  = 16,
  parameter int unsigned MAP_HEIGHT = 16
);
  logic                  o_wrt;
  logic                  i_full;
  logic [DATA_WIDTH-1:0] o_node_f;
  logic [MAP_WIDTH-1:0]  o_node_i;
  logic [MAP_HEIGHT-1:0] o_node_j;

  modport master (output o_wrt, o_node_f, o_node_i, o_node_j, input i_full);
  modport slave  (input o_wrt, o_node_f, o_node_i, o_node_j, output i_full);
endinterface

// File: rtl/heuristic_calc.sv
// Combinational heuristic: Manhattan by default, Chebyshev with NEIGHBOR_DIAG_EN.
module heuristic_calc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAP_WIDTH  = 16,
  parameter int unsigned MAP_HEIGHT = 16
) (
  input  logic [MAP_WIDTH-1:0]  pos_x_i,
  input  logic [MAP_HEIGHT-1:0] pos_y_i,
  input  logic [MAP_WIDTH-1:0]  goal_x_i,
  input  logic [MAP_HEIGHT-1:0] goal_y_i,
  output logic [DATA_WIDTH-1:0] h_o
);
  logic [MAP_WIDTH-1:0]  adx;
  logic [MAP_HEIGHT-1:0] ady;
  logic [DATA_WIDTH-1:0] adx_w, ady_w;

  assign adx   = (pos_x_i >= goal_x_i) ? pos_x_i - goal_x_i : goal_x_i - pos_x_i;
  assign ady   = (pos_y_i >= goal_y_i) ? pos_y_i - goal_y_i : goal_y_i - pos_y_i;
  assign adx_w = DATA_WIDTH'(adx);
  assign ady_w = DATA_WIDTH'(ady);

`ifdef NEIGHBOR_DIAG_EN
  assign h_o = (adx_w >= ady_w) ? adx_w : ady_w;
`else
  assign h_o = adx_w + ady_w;
`endif
endmodule

// File: rtl/neighbor_expander.sv
// A* expansion stage: walks the neighbours of one parent and pushes (f, i, j) to the open list.
// Neighbour count and heuristic follow NEIGHBOR_DIAG_EN (see astar_pkg / heuristic_calc).
module neighbor_expander
  import astar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAP_WIDTH  = 16,
  parameter int unsigned MAP_HEIGHT = 16,
  parameter int unsigned GRID_W     = 16,
  parameter int unsigned GRID_H     = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_start,
  input  logic [MAP_WIDTH-1:0]  i_node_i,
  input  logic [MAP_HEIGHT-1:0] i_node_j,
  input  logic [DATA_WIDTH-1:0] i_node_g,
  input  logic [MAP_WIDTH-1:0]  i_goal_i,
  input  logic [MAP_HEIGHT-1:0] i_goal_j,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_obs_req,
  output logic [MAP_WIDTH-1:0]  o_obs_i,
  output logic [MAP_HEIGHT-1:0] o_obs_j,
  input  logic                  i_obs_blocked,
  neighbor_expander_if.master   ol,
  output logic [3:0]            o_pushed
);
  localparam logic [MAP_WIDTH:0]  GridWLim = (MAP_WIDTH + 1)'(GRID_W);
  localparam logic [MAP_HEIGHT:0] GridHLim = (MAP_HEIGHT + 1)'(GRID_H);

  exp_state_e            state_q, state_d;
  dir_e                  d_q, d_d;
  logic [MAP_WIDTH-1:0]  par_i_q, par_i_d, goal_i_q, goal_i_d, node_i_q, node_i_d;
  logic [MAP_HEIGHT-1:0] par_j_q, par_j_d, goal_j_q, goal_j_d, node_j_q, node_j_d;
  logic [DATA_WIDTH-1:0] g_q, g_d, node_f_q, node_f_d;
  logic [3:0]            pushed_q, pushed_d;

  logic signed [1:0]     di, dj;
  logic [MAP_WIDTH-1:0]  nb_i;
  logic [MAP_HEIGHT-1:0] nb_j;
  logic                  in_bounds;
  logic [DATA_WIDTH-1:0] h, f_sat;
  logic [DATA_WIDTH+1:0] f_wide;

  // Neighbour coordinate for the current direction; out-of-grid steps never wrap.
  always_comb begin
    di        = DirDi[d_q];
    dj        = DirDj[d_q];
    nb_i      = par_i_q;
    nb_j      = par_j_q;
    in_bounds = 1'b1;
    if (di == 2'sb01) begin
      nb_i = par_i_q + MAP_WIDTH'(1);
      if (({1'b0, par_i_q} + (MAP_WIDTH + 1)'(1)) >= GridWLim) in_bounds = 1'b0;
    end else if (di == 2'sb11) begin
      nb_i = par_i_q - MAP_WIDTH'(1);
      if (par_i_q == '0) in_bounds = 1'b0;
    end
    if (dj == 2'sb01) begin
      nb_j = par_j_q + MAP_HEIGHT'(1);
      if (({1'b0, par_j_q} + (MAP_HEIGHT + 1)'(1)) >= GridHLim) in_bounds = 1'b0;
    end else if (dj == 2'sb11) begin
      nb_j = par_j_q - MAP_HEIGHT'(1);
      if (par_j_q == '0) in_bounds = 1'b0;
    end
  end

  heuristic_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAP_WIDTH  (MAP_WIDTH),
    .MAP_HEIGHT (MAP_HEIGHT)
  ) u_heuristic (
    .pos_x_i  (nb_i),
    .pos_y_i  (nb_j),
    .goal_x_i (goal_i_q),
    .goal_y_i (goal_j_q),
    .h_o      (h)
  );

  // Two guard bits catch any carry out of g + 1 + h; saturate rather than wrap.
  assign f_wide = {2'b00, g_q} + (DATA_WIDTH + 2)'(1) + {2'b00, h};
  assign f_sat  = (f_wide[DATA_WIDTH+1:DATA_WIDTH] != 2'b00) ? '1 : f_wide[DATA_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    par_i_d   = par_i_q;
    par_j_d   = par_j_q;
    goal_i_d  = goal_i_q;
    goal_j_d  = goal_j_q;
    g_d       = g_q;
    node_f_d  = node_f_q;
    node_i_d  = node_i_q;
    node_j_d  = node_j_q;
    pushed_d  = pushed_q;
    o_obs_req = 1'b0;
    o_obs_i   = '0;
    o_obs_j   = '0;
    ol.o_wrt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          par_i_d  = i_node_i;
          par_j_d  = i_node_j;
          g_d      = i_node_g;
          goal_i_d = i_goal_i;
          goal_j_d = i_goal_j;
          d_d      = DirN;
          pushed_d = '0;
          state_d  = StGen;
        end
      end
      StGen: begin
        if (in_bounds) begin
          o_obs_req = 1'b1;
          o_obs_i   = nb_i;
          o_obs_j   = nb_j;
          state_d   = StLookup;
        end else begin
          state_d = StNext;
        end
      end
      StLookup: begin
        if (i_obs_blocked) begin
          state_d = StNext;
        end else begin
          node_f_d = f_sat;
          node_i_d = nb_i;
          node_j_d = nb_j;
          state_d  = StPush;
        end
      end
      StPush: begin
        if (!ol.i_full) begin
          ol.o_wrt = 1'b1;
          pushed_d = pushed_q + 4'd1;
          state_d  = StNext;
        end
      end
      StNext: begin
        if (d_q == LastDir) begin
          state_d = StDone;
        end else begin
          d_d     = dir_e'(d_q + 3'd1);
          state_d = StGen;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      state_q  <= StIdle;
      d_q      <= DirN;
      par_i_q  <= '0;
      par_j_q  <= '0;
      goal_i_q <= '0;
      goal_j_q <= '0;
      g_q      <= '0;
      node_f_q <= '0;
      node_i_q <= '0;
      node_j_q <= '0;
      pushed_q <= '0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      par_i_q  <= par_i_d;
      par_j_q  <= par_j_d;
      goal_i_q <= goal_i_d;
      goal_j_q <= goal_j_d;
      g_q      <= g_d;
      node_f_q <= node_f_d;
      node_i_q <= node_i_d;
      node_j_q <= node_j_d;
      pushed_q <= pushed_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StDone);
  assign o_pushed    = pushed_q;
  assign ol.o_node_f = node_f_q;
  assign ol.o_node_i = node_i_q;
  assign ol.o_node_j = node_j_q;
endmodule

// File: tb/tb_neighbor_expander.sv
// Scoreboard bench for neighbor_expander (default 4-direction build).
module tb_neighbor_expander;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        i_start;
  logic [15:0] i_node_i, i_node_j, i_goal_i, i_goal_j;
  logic [31:0] i_node_g;
  logic        o_busy, o_done, o_obs_req;
  logic [15:0] o_obs_i, o_obs_j;
  logic        i_obs_blocked = 1'b0;
  logic [3:0]  o_pushed;

  neighbor_expander_if #(.DATA_WIDTH(32), .MAP_WIDTH(16), .MAP_HEIGHT(16)) ol ();

  neighbor_expander #(
    .DATA_WIDTH (32),
    .MAP_WIDTH  (16),
    .MAP_HEIGHT (16),
    .GRID_W     (16),
    .GRID_H     (16)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .i_start       (i_start),
    .i_node_i      (i_node_i),
    .i_node_j      (i_node_j),
    .i_node_g      (i_node_g),
    .i_goal_i      (i_goal_i),
    .i_goal_j      (i_goal_j),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_obs_req     (o_obs_req),
    .o_obs_i       (o_obs_i),
    .o_obs_j       (o_obs_j),
    .i_obs_blocked (i_obs_blocked),
    .ol            (ol),
    .o_pushed      (o_pushed)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] f;
    logic [15:0] i;
    logic [15:0] j;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_chk = 0;
  int  n_bad = 0;
  int  obs_reqs = 0;
  wr_t e;

  // Obstacle map: a single blockable cell, one-cycle read latency.
  logic        obs_en = 1'b0;
  logic [15:0] obs_x = '0, obs_y = '0;
  always @(posedge CLK)
    i_obs_blocked <= obs_en && o_obs_req && (o_obs_i == obs_x) && (o_obs_j == obs_y);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] f, input logic [15:0] i, input logic [15:0] j);
    wr_t w;
    w.f = f;
    w.i = i;
    w.j = j;
    exp_wr.push_back(w);
  endtask

  // Monitor: pops the scoreboard on every write and every done pulse.
  always @(negedge CLK) begin
    if (o_obs_req) obs_reqs++;
    if (ol.o_wrt) begin
      chk("wrt_with_full", {63'd0, ol.i_full}, 64'd0);
      if (exp_wr.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_write: got (%0d,%0d) f=%0h expected none",
                 ol.o_node_i, ol.o_node_j, ol.o_node_f);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_f", {32'd0, ol.o_node_f}, {32'd0, e.f});
        chk("wr_i", {48'd0, ol.o_node_i}, {48'd0, e.i});
        chk("wr_j", {48'd0, ol.o_node_j}, {48'd0, e.j});
      end
    end
    if (o_done) begin
      if (exp_done.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done: got pushed=%0d expected no done", o_pushed);
      end else begin
        chk("pushed", {60'd0, o_pushed}, 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Returns with the bench at cycle 1 (GEN of the first direction), 1ns after the start edge.
  task automatic start_node(input logic [15:0] pi, input logic [15:0] pj, input logic [31:0] g,
                            input logic [15:0] gi, input logic [15:0] gj);
    cyc();
    i_node_i = pi;
    i_node_j = pj;
    i_node_g = g;
    i_goal_i = gi;
    i_goal_j = gj;
    i_start  = 1'b1;
    cyc();
    i_start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (o_done) return;
      @(posedge CLK);
      #1;
      n++;
    end
    n_chk++;
    n_bad++;
    $display("FAIL done_timeout: got no o_done expected within 200 cycles");
  endtask

  task automatic push_centre(input logic [31:0] g);
    // Parent (5,5), goal (8,5): N h=4, E h=2, S h=4, W h=4.
    push_exp((g == 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : g + 32'd5, 16'd5, 16'd4);
    push_exp((g == 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : g + 32'd3, 16'd6, 16'd5);
    push_exp((g == 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : g + 32'd5, 16'd5, 16'd6);
    push_exp((g == 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : g + 32'd5, 16'd4, 16'd5);
  endtask

  int n;

  initial begin
    RSTn     = 1'b1;
    i_start  = 1'b0;
    i_node_i = '0;
    i_node_j = '0;
    i_node_g = '0;
    i_goal_i = '0;
    i_goal_j = '0;
    ol.i_full = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy",    {63'd0, o_busy},    64'd0);
    chk("rst_done",    {63'd0, o_done},    64'd0);
    chk("rst_wrt",     {63'd0, ol.o_wrt},  64'd0);
    chk("rst_obs_req", {63'd0, o_obs_req}, 64'd0);
    chk("rst_pushed",  {60'd0, o_pushed},  64'd0);
    chk("rst_node_f",  {32'd0, ol.o_node_f}, 64'd0);
    RSTn = 1'b0;

    // Centre expansion, all four neighbours written.
    push_centre(32'd3);
    exp_done.push_back(4);
    obs_reqs = 0;
    start_node(16'd5, 16'd5, 32'd3, 16'd8, 16'd5);
    wait_done(n);
    // 4 x (GEN, LOOKUP, PUSH, NEXT) then DONE.
    chk("centre_done_cycle", 64'(n), 64'd17);
    chk("centre_obs_reqs", 64'(obs_reqs), 64'd4);

    // Corner: N and W rejected without an obstacle read.
    push_exp(32'd6, 16'd1, 16'd0);
    push_exp(32'd6, 16'd0, 16'd1);
    exp_done.push_back(2);
    obs_reqs = 0;
    start_node(16'd0, 16'd0, 32'd0, 16'd3, 16'd3);
    wait_done(n);
    chk("corner_obs_reqs", 64'(obs_reqs), 64'd2);

    // Obstacle at E; a start pulse mid-expansion must be ignored.
    obs_en = 1'b1;
    obs_x  = 16'd6;
    obs_y  = 16'd5;
    push_exp(32'd8, 16'd5, 16'd4);
    push_exp(32'd8, 16'd5, 16'd6);
    push_exp(32'd8, 16'd4, 16'd5);
    exp_done.push_back(3);
    start_node(16'd5, 16'd5, 32'd3, 16'd8, 16'd5);
    cyc();
    chk("busy_mid", {63'd0, o_busy}, 64'd1);
    i_node_i = 16'd0;
    i_node_j = 16'd0;
    i_start  = 1'b1;
    cyc();
    i_start = 1'b0;
    wait_done(n);
    obs_en = 1'b0;

    // Backpressure: full for the first 5 cycles of the first PUSH.
    push_centre(32'd3);
    exp_done.push_back(4);
    ol.i_full = 1'b1;
    start_node(16'd5, 16'd5, 32'd3, 16'd8, 16'd5);
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("stall_wrt", {63'd0, ol.o_wrt}, 64'd0);
      chk("stall_f", {32'd0, ol.o_node_f}, 64'd8);
      chk("stall_i", {48'd0, ol.o_node_i}, 64'd5);
      chk("stall_j", {48'd0, ol.o_node_j}, 64'd4);
      @(posedge CLK);
      #1;
    end
    ol.i_full = 1'b0;
    wait_done(n);

    // Saturation.
    push_centre(32'hFFFF_FFFE);
    exp_done.push_back(4);
    start_node(16'd5, 16'd5, 32'hFFFF_FFFE, 16'd8, 16'd5);
    wait_done(n);

    // Reset during the second LOOKUP (cycle 6): only N was written, no done.
    push_exp(32'd8, 16'd5, 16'd4);
    start_node(16'd5, 16'd5, 32'd3, 16'd8, 16'd5);
    repeat (5) cyc();
    RSTn = 1'b1;
    #1;
    chk("mid_rst_busy",    {63'd0, o_busy},    64'd0);
    chk("mid_rst_wrt",     {63'd0, ol.o_wrt},  64'd0);
    chk("mid_rst_obs_req", {63'd0, o_obs_req}, 64'd0);
    chk("mid_rst_pushed",  {60'd0, o_pushed},  64'd0);
    chk("mid_rst_node_f",  {32'd0, ol.o_node_f}, 64'd0);
    chk("mid_rst_node_i",  {48'd0, ol.o_node_i}, 64'd0);
    cyc();
    RSTn = 1'b0;
    push_centre(32'd3);
    exp_done.push_back(4);
    start_node(16'd5, 16'd5, 32'd3, 16'd8, 16'd5);
    wait_done(n);
    cyc();

    chk("left_writes", 64'(exp_wr.size()), 64'd0);
    chk("left_dones", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
